// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between the fetch and load/store ports.
// Define RR_ARB_EN for round-robin arbitration; otherwise data has fixed priority.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              owner_d, owner_next;
  logic              pick_d, pick_if;
  logic              if_gnt_int, d_gnt_int, mem_en_int, mem_we_int;
  logic [ADDR_W-1:0] mem_addr_int;
  logic [DATA_W-1:0] mem_wdata_int;

`ifdef RR_ARB_EN
  // last_d = 1 means the data port won the most recent grant.
  logic last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b1;
    end else if (if_gnt_int || d_gnt_int) begin
      last_d <= d_gnt_int;
    end
  end

  assign pick_d = d_req && (!if_req || !last_d);
`else
  assign pick_d = d_req;
`endif

  assign pick_if = if_req && !pick_d;

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    owner_next    = owner_d;
    if_gnt_int    = 1'b0;
    d_gnt_int     = 1'b0;
    mem_en_int    = 1'b0;
    mem_we_int    = 1'b0;
    mem_addr_int  = '0;
    mem_wdata_int = '0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          d_gnt_int     = 1'b1;
          mem_en_int    = 1'b1;
          mem_we_int    = d_we;
          mem_addr_int  = d_addr;
          mem_wdata_int = d_wdata;
          if (!d_we) begin
            owner_next = 1'b1;
            cnt_next   = LAT_CNT;
            state_next = WAIT;
          end
        end else if (pick_if) begin
          if_gnt_int   = 1'b1;
          mem_en_int   = 1'b1;
          mem_addr_int = if_addr;
          owner_next   = 1'b0;
          cnt_next     = LAT_CNT;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs are forced quiet while reset is held.
  assign if_gnt    = rst & if_gnt_int;
  assign d_gnt     = rst & d_gnt_int;
  assign mem_en    = rst & mem_en_int;
  assign mem_we    = rst & mem_we_int;
  assign mem_addr  = rst ? mem_addr_int : '0;
  assign mem_wdata = rst ? mem_wdata_int : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner_d   <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      owner_d   <= owner_next;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (state == WAIT && cnt == 4'd1) begin
        if (owner_d) begin
          d_rvalid <= 1'b1;
          d_rdata  <= mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized and directed checks of unified_mem_arbiter against a transaction-level model.
// Also covers round-robin arbitration when compiled with RR_ARB_EN.
module tb_unified_mem_arbiter;
  localparam int LAT = 2;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial memory image shared by the environment memory and the model.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Environment memory: fixed read latency, garbage when no read is in flight.
  logic [31:0] env_mem     [1024];
  bit          env_written [1024];
  logic [31:0] rd_pipe     [LAT];

  function automatic logic [31:0] env_word(input logic [31:0] a);
    return env_written[a[11:2]] ? env_mem[a[11:2]] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      env_mem[mem_addr[11:2]]     <= mem_wdata;
      env_written[mem_addr[11:2]] <= 1'b1;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? env_word(mem_addr) : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model state.
  logic [31:0] ref_mem     [1024];
  bit          ref_written [1024];
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;
  bit          ref_last_d   = 1'b1;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_written[a[11:2]] ? ref_mem[a[11:2]] : init_word(a);
  endfunction

  function automatic bit exp_winner_d(input bit ir, input bit dr);
    if (ir && dr) begin
`ifdef RR_ARB_EN
      return !ref_last_d;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".if_gnt"},    32'(if_gnt),    32'd0);
    chk({tag, ".d_gnt"},     32'(d_gnt),     32'd0);
    chk({tag, ".mem_en"},    32'(mem_en),    32'd0);
    chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
    chk({tag, ".mem_addr"},  mem_addr,       32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'd0);
    chk({tag, ".if_rdata"},  if_rdata,       32'd0);
    chk({tag, ".d_rdata"},   d_rdata,        32'd0);
  endtask

  task automatic grant_check(input bit is_d, input logic [31:0] a, input bit we,
                             input logic [31:0] wd);
    $display("txn %s %s addr=%h wdata=%h", is_d ? "D " : "IF",
             (is_d && we) ? "store" : "read ", a, wd);
    chk("if_gnt",   32'(if_gnt),  32'(!is_d));
    chk("d_gnt",    32'(d_gnt),   32'(is_d));
    chk("mem_en",   32'(mem_en),  32'd1);
    chk("mem_we",   32'(mem_we),  32'(is_d && we));
    chk("mem_addr", mem_addr,     a);
    if (is_d && we) chk("mem_wdata", mem_wdata, wd);
    ref_last_d = is_d;
  endtask

  // Covers the MEM_LAT+1 cycles after a read grant; noise requests must be ignored.
  task automatic finish_read(input bit is_d, input logic [31:0] a, input bit noise);
    for (int k = 1; k <= LAT + 1; k++) begin
      if (noise) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom & 32'hFFC;
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom & 32'hFFC;
        d_wdata = $urandom;
      end
      @(negedge clk);
      chk("busy.if_gnt", 32'(if_gnt), 32'd0);
      chk("busy.d_gnt",  32'(d_gnt),  32'd0);
      chk("busy.mem_en", 32'(mem_en), 32'd0);
      if (k == LAT + 1) begin
        if (is_d) exp_d_rdata = ref_read(a);
        else      exp_if_rdata = ref_read(a);
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(!is_d && k == LAT + 1));
      chk("d_rvalid",  32'(d_rvalid),  32'(is_d && k == LAT + 1));
      chk("if_rdata",  if_rdata, exp_if_rdata);
      chk("d_rdata",   d_rdata,  exp_d_rdata);
      next_cycle();
    end
    if (noise) begin
      if_req = 1'b0;
      d_req  = 1'b0;
    end
  endtask

  task automatic issue_read(input bit is_d, input logic [31:0] a, input bit noise);
    if_req = !is_d;
    if_addr = a;
    d_req = is_d;
    d_we = 1'b0;
    d_addr = a;
    @(negedge clk);
    grant_check(is_d, a, 1'b0, 32'd0);
    next_cycle();
    if_req = 1'b0;
    d_req  = 1'b0;
    finish_read(is_d, a, noise);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit          w, ir, dr, dwe;
    logic [31:0] ia, da, dwd;

    rst = 1'b0; if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234;
    @(negedge clk);
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    // Single fetch of the known instruction word.
    issue_read(1'b0, 32'h40, 1'b0);
    chk("fetch.data", if_rdata, 32'h00500093);
    @(negedge clk);
    chk("idle.mem_en", 32'(mem_en), 32'd0);
    chk("idle.mem_we", 32'(mem_we), 32'd0);
    next_cycle();

    // Back-to-back stores, then read each one back.
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100 + 32'(4 * i); d_wdata = $urandom;
      @(negedge clk);
      grant_check(1'b1, d_addr, 1'b1, d_wdata);
      ref_mem[d_addr[11:2]] = d_wdata;
      ref_written[d_addr[11:2]] = 1'b1;
      next_cycle();
    end
    d_req = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 3; i++) issue_read(1'b1, 32'h100 + 32'(4 * i), 1'b1);

    // Contention: both ports request; loser keeps its request held.
    if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    w = exp_winner_d(1'b1, 1'b1);
    @(negedge clk);
    grant_check(w, w ? 32'h200 : 32'h44, 1'b0, 32'd0);
    next_cycle();
    if (w) d_req = 1'b0; else if_req = 1'b0;
    finish_read(w, w ? 32'h200 : 32'h44, 1'b0);
    @(negedge clk);
    grant_check(!w, w ? 32'h44 : 32'h200, 1'b0, 32'd0);
    next_cycle();
    if_req = 1'b0; d_req = 1'b0;
    finish_read(!w, w ? 32'h44 : 32'h200, 1'b0);

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      ir  = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      dwe = 1'($urandom_range(0, 1));
      ia  = 32'h300 | (32'($urandom_range(0, 3)) << 2);
      da  = 32'h300 | (32'($urandom_range(0, 3)) << 2);
      dwd = $urandom;
      if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
      if (!ir && !dr) begin
        @(negedge clk);
        chk("none.if_gnt", 32'(if_gnt), 32'd0);
        chk("none.d_gnt",  32'(d_gnt),  32'd0);
        chk("none.mem_en", 32'(mem_en), 32'd0);
        next_cycle();
        continue;
      end
      w = exp_winner_d(ir, dr);
      @(negedge clk);
      grant_check(w, w ? da : ia, dwe, dwd);
      if (w && dwe) begin
        ref_mem[da[11:2]] = dwd;
        ref_written[da[11:2]] = 1'b1;
        next_cycle();
        if_req = 1'b0; d_req = 1'b0;
      end else begin
        next_cycle();
        if_req = 1'b0; d_req = 1'b0;
        finish_read(w, w ? da : ia, 1'b1);
      end
    end

    // Reset during WAIT discards the fetch in flight.
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    grant_check(1'b0, 32'h40, 1'b0, 32'd0);
    next_cycle();
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1;
    exp_if_rdata = '0; exp_d_rdata = '0; ref_last_d = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    next_cycle();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("post.if_rvalid", 32'(if_rvalid), 32'd0);
      chk("post.d_rvalid",  32'(d_rvalid),  32'd0);
      chk("post.mem_en",    32'(mem_en),    32'd0);
      next_cycle();
    end

    // Both ports requesting continuously: grant order follows the arbitration rule.
    if_req = 1'b1; if_addr = 32'h48; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      w = exp_winner_d(1'b1, 1'b1);
      @(negedge clk);
      grant_check(w, w ? 32'h300 : 32'h48, 1'b0, 32'd0);
      next_cycle();
      finish_read(w, w ? 32'h300 : 32'h48, 1'b0);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("end.mem_en", 32'(mem_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
